// File: rtl/dcache_refill_unit.sv
// Miss path behind the dcache: dirty-victim write-back, then block refill, one beat per handshake.
// Optional build macro REFILL_CRITICAL_FIRST_EN starts the refill at the missing beat and wraps.
module dcache_refill_unit #(
    parameter int unsigned ADDR_BITS        = 8,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned CACHE_BLOCK_SIZE = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  miss_valid,
    input  logic [ADDR_BITS-1:0]                  miss_address,
    input  logic                                  miss_evict,
    input  logic [ADDR_BITS-1:0]                  evict_address,
    input  logic [CACHE_BLOCK_SIZE*DATA_BITS-1:0] evict_data,
    output logic                                  miss_ready,
    output logic [CACHE_BLOCK_SIZE*DATA_BITS-1:0] fill_data,
    output logic                                  busy,
    output logic                                  mem_read_valid,
    output logic [ADDR_BITS-1:0]                  mem_read_address,
    input  logic                                  mem_read_ready,
    input  logic [DATA_BITS-1:0]                  mem_read_data,
    output logic                                  mem_write_valid,
    output logic [ADDR_BITS-1:0]                  mem_write_address,
    output logic [DATA_BITS-1:0]                  mem_write_data,
    input  logic                                  mem_write_ready
);

    localparam int unsigned OFS = $clog2(CACHE_BLOCK_SIZE);
    localparam int unsigned TAG = ADDR_BITS - OFS;
    localparam int unsigned BLK = CACHE_BLOCK_SIZE * DATA_BITS;
    localparam logic [OFS-1:0] LAST_BEAT = OFS'(CACHE_BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_REQ = 3'd1,
        WB_ACK = 3'd2,
        RD_REQ = 3'd3,
        RD_ACK = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t         state, state_n;
    logic [OFS-1:0] beat, beat_n;
    logic [TAG-1:0] miss_tag_q, miss_tag_n;
    logic [OFS-1:0] first_ofs_q, first_ofs_n;
    logic [TAG-1:0] evict_tag_q, evict_tag_n;
    logic [BLK-1:0] evict_data_q, evict_data_n;

    logic                 miss_ready_n, busy_n;
    logic                 rd_valid_n, wr_valid_n;
    logic [ADDR_BITS-1:0] rd_addr_n, wr_addr_n;
    logic [DATA_BITS-1:0] wr_data_n;
    logic [BLK-1:0]       fill_data_n;

    logic [OFS-1:0] first_ofs_c;
    logic [OFS-1:0] beat_inc;
    logic [OFS-1:0] rd_slot;
    logic           unused_ofs;

    // Offset arithmetic stays inside the OFS-bit field, so it never carries into the tag.
`ifdef REFILL_CRITICAL_FIRST_EN
    assign first_ofs_c = miss_address[OFS-1:0];
    assign unused_ofs  = ^evict_address[OFS-1:0];
`else
    assign first_ofs_c = '0;
    assign unused_ofs  = ^{evict_address[OFS-1:0], miss_address[OFS-1:0]};
`endif
    assign beat_inc = beat + OFS'(1);
    assign rd_slot  = beat + first_ofs_q;

    // Next-state and next-output decode
    always_comb begin
        state_n      = state;
        beat_n       = beat;
        miss_tag_n   = miss_tag_q;
        first_ofs_n  = first_ofs_q;
        evict_tag_n  = evict_tag_q;
        evict_data_n = evict_data_q;
        miss_ready_n = miss_ready;
        rd_valid_n   = mem_read_valid;
        rd_addr_n    = mem_read_address;
        wr_valid_n   = mem_write_valid;
        wr_addr_n    = mem_write_address;
        wr_data_n    = mem_write_data;
        fill_data_n  = fill_data;

        case (state)
            IDLE: begin
                if (miss_valid) begin
                    miss_tag_n   = miss_address[ADDR_BITS-1:OFS];
                    first_ofs_n  = first_ofs_c;
                    evict_tag_n  = evict_address[ADDR_BITS-1:OFS];
                    evict_data_n = evict_data;
                    beat_n       = '0;
                    if (miss_evict) begin
                        state_n    = WB_REQ;
                        wr_valid_n = 1'b1;
                        wr_addr_n  = {evict_address[ADDR_BITS-1:OFS], OFS'(0)};
                        wr_data_n  = evict_data[DATA_BITS-1:0];
                    end else begin
                        state_n    = RD_REQ;
                        rd_valid_n = 1'b1;
                        rd_addr_n  = {miss_address[ADDR_BITS-1:OFS], first_ofs_c};
                    end
                end
            end
            WB_REQ: begin
                if (mem_write_ready) begin
                    wr_valid_n = 1'b0;
                    state_n    = WB_ACK;
                end
            end
            WB_ACK: begin
                if (!mem_write_ready) begin
                    if (beat == LAST_BEAT) begin
                        beat_n     = '0;
                        state_n    = RD_REQ;
                        rd_valid_n = 1'b1;
                        rd_addr_n  = {miss_tag_q, first_ofs_q};
                    end else begin
                        beat_n     = beat_inc;
                        state_n    = WB_REQ;
                        wr_valid_n = 1'b1;
                        wr_addr_n  = {evict_tag_q, beat_inc};
                        wr_data_n  = evict_data_q[beat_inc*DATA_BITS +: DATA_BITS];
                    end
                end
            end
            RD_REQ: begin
                if (mem_read_ready) begin
                    rd_valid_n = 1'b0;
                    fill_data_n[rd_slot*DATA_BITS +: DATA_BITS] = mem_read_data;
                    state_n    = RD_ACK;
                end
            end
            RD_ACK: begin
                if (!mem_read_ready) begin
                    if (beat == LAST_BEAT) begin
                        beat_n       = '0;
                        state_n      = DONE;
                        miss_ready_n = 1'b1;
                    end else begin
                        beat_n     = beat_inc;
                        state_n    = RD_REQ;
                        rd_valid_n = 1'b1;
                        rd_addr_n  = {miss_tag_q, beat_inc + first_ofs_q};
                    end
                end
            end
            DONE: begin
                if (!miss_valid) begin
                    miss_ready_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            beat              <= '0;
            miss_tag_q        <= '0;
            first_ofs_q       <= '0;
            evict_tag_q       <= '0;
            evict_data_q      <= '0;
            miss_ready        <= 1'b0;
            busy              <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            fill_data         <= '0;
        end else begin
            state             <= state_n;
            beat              <= beat_n;
            miss_tag_q        <= miss_tag_n;
            first_ofs_q       <= first_ofs_n;
            evict_tag_q       <= evict_tag_n;
            evict_data_q      <= evict_data_n;
            miss_ready        <= miss_ready_n;
            busy              <= busy_n;
            mem_read_valid    <= rd_valid_n;
            mem_read_address  <= rd_addr_n;
            mem_write_valid   <= wr_valid_n;
            mem_write_address <= wr_addr_n;
            mem_write_data    <= wr_data_n;
            fill_data         <= fill_data_n;
        end
    end

endmodule
